// File: rtl/spi_sub_burst_pkg.sv
// ============================================================================
// Module   : spi_sub_pkg
// Purpose  : Shared FSM state and opcode types for the spi_sub_burst bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_sub_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        WDATA = 3'd2,
        MEM   = 3'd3,
        LOAD  = 3'd4,
        RESP  = 3'd5,
        DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_BRD = 2'b10,
        OP_BWR = 2'b11
    } op_t;

    function automatic logic op_is_write(input op_t op);
        return op[0];
    endfunction

    function automatic logic op_is_burst(input op_t op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sub_burst_if.sv
// ============================================================================
// Module   : spi_sub_burst_if
// Purpose  : SPI pad and memory-side signal bundle of spi_sub_burst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_sub_burst_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              r_en;
    logic              w_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] data_i;
    logic              frame_err;

    modport slave (
        input  cs_n, mosi, data_i,
        output miso, r_en, w_en, addr, data_o, frame_err
    );

    modport master (
        output cs_n, mosi, data_i,
        input  miso, r_en, w_en, addr, data_o, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/spi_sub_burst_shifter.sv
// ============================================================================
// Module   : spi_sub_shifter
// Purpose  : Shift register with bit counter, parallel load and a negedge
//            serial-out flop (MSB first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sub_shifter #(
    parameter int W     = 32,
    parameter int CNT_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_shift,
    input  wire logic             i_load,
    input  wire logic [W-1:0]     i_load_val,
    input  wire logic             i_sin,
    input  wire logic             i_oe,
    output logic      [W-1:0]     o_data,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_sout
);
    logic [W-1:0]     r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_load_val;
            r_cnt  <= '0;
        end else begin
            if (i_shift)
                r_data <= {r_data[W-2:0], i_sin};
            if (i_clr)
                r_cnt <= '0;
            else if (i_shift)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Output is presented half a cycle ahead of the master's sampling edge.
    always_ff @(negedge clk) begin
        if (rst || !i_oe)
            r_sout <= 1'b0;
        else
            r_sout <= r_data[W-1];
    end

    assign o_data = r_data;
    assign o_cnt  = r_cnt;
    assign o_sout = r_sout;
endmodule

`default_nettype wire

// File: rtl/spi_sub_burst.sv
// ============================================================================
// Module   : spi_sub_burst
// Purpose  : SPI mode-0 subordinate bridging to a synchronous memory with
//            incrementing burst reads/writes. Define SPI_SUB_WR_ECHO_EN to
//            echo each written word back on miso.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sub_burst
    import spi_sub_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  wire logic       sclk,
    input  wire logic       rst,
    spi_sub_burst_if.slave  bus
);
    localparam int c_H     = 2 + ADDR_W + LEN_W;
    localparam int c_RX_W  = (c_H > DATA_W) ? c_H : DATA_W;
    localparam int c_CNT_W = $clog2(c_RX_W);
    localparam logic [c_CNT_W-1:0] c_HDR_LAST = c_CNT_W'(c_H - 1);
    localparam logic [c_CNT_W-1:0] c_DAT_LAST = c_CNT_W'(DATA_W - 1);

    state_t            r_state, w_next;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data_o;
    logic [LEN_W-1:0]  r_words;
    logic              r_frame_err;

    logic [c_RX_W-2:0]  w_rx_data;
    logic [c_CNT_W-1:0] w_rx_cnt, w_tx_cnt;
    logic [c_H-1:0]     w_hdr;
    logic [DATA_W-1:0]  w_word;
    op_t                w_op;
    logic w_rx_shift, w_rx_clr, w_tx_load, w_tx_shift, w_tx_clr, w_tx_oe;
    logic w_hdr_done, w_wdata_done, w_advance, w_abort, w_frame_start;

    // The bit on mosi at the capturing edge completes the field.
    assign w_hdr  = {w_rx_data[c_H-2:0], bus.mosi};
    assign w_word = {w_rx_data[DATA_W-2:0], bus.mosi};
    assign w_op   = op_t'(w_hdr[c_H-1 -: 2]);

    always_ff @(posedge sclk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_rx_shift    = 1'b0;
        w_rx_clr      = 1'b0;
        w_tx_load     = 1'b0;
        w_tx_shift    = 1'b0;
        w_tx_clr      = 1'b0;
        w_hdr_done    = 1'b0;
        w_wdata_done  = 1'b0;
        w_advance     = 1'b0;
        w_abort       = 1'b0;
        w_frame_start = 1'b0;
        if (bus.cs_n) begin
            w_next   = IDLE;
            w_rx_clr = 1'b1;
            w_tx_clr = 1'b1;
            w_abort  = (r_state inside {HDR, WDATA, MEM, LOAD, RESP});
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_rx_shift    = 1'b1;
                    w_frame_start = 1'b1;
                    w_next        = HDR;
                end
                HDR: begin
                    w_rx_shift = 1'b1;
                    if (w_rx_cnt == c_HDR_LAST) begin
                        w_hdr_done = 1'b1;
                        w_rx_clr   = 1'b1;
                        w_next     = op_is_write(w_op) ? WDATA : MEM;
                    end
                end
                WDATA: begin
                    w_rx_shift = 1'b1;
                    if (w_rx_cnt == c_DAT_LAST) begin
                        w_wdata_done = 1'b1;
                        w_rx_clr     = 1'b1;
                        w_next       = MEM;
                    end
                end
                MEM: begin
`ifdef SPI_SUB_WR_ECHO_EN
                    w_next = LOAD;
`else
                    if (!r_wr)
                        w_next = LOAD;
                    else if (r_words != '0) begin
                        w_advance = 1'b1;
                        w_next    = WDATA;
                    end else
                        w_next = DONE;
`endif
                end
                LOAD: begin
                    w_tx_load = 1'b1;
                    w_next    = RESP;
                end
                RESP: begin
                    w_tx_shift = 1'b1;
                    if (w_tx_cnt == c_DAT_LAST) begin
                        if (r_words != '0) begin
                            w_advance = 1'b1;
                            w_next    = r_wr ? WDATA : MEM;
                        end else
                            w_next = DONE;
                    end
                end
                DONE:    w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_data_o    <= '0;
            r_words     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_abort)
                r_frame_err <= 1'b1;
            else if (w_frame_start)
                r_frame_err <= 1'b0;
            if (w_hdr_done) begin
                r_wr    <= op_is_write(w_op);
                r_addr  <= w_hdr[LEN_W +: ADDR_W];
                r_words <= op_is_burst(w_op) ? w_hdr[LEN_W-1:0] : '0;
            end
            if (w_wdata_done)
                r_data_o <= w_word;
            if (bus.cs_n)
                r_words <= '0;
            else if (w_advance) begin
                r_addr  <= r_addr + 1'b1;
                r_words <= r_words - 1'b1;
            end
        end
    end

    assign w_tx_oe = (r_state == RESP) && !bus.cs_n && !rst;

    spi_sub_shifter #(.W(c_RX_W - 1), .CNT_W(c_CNT_W)) u_rx (
        .clk        (sclk),
        .rst        (rst),
        .i_clr      (w_rx_clr),
        .i_shift    (w_rx_shift),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_sin      (bus.mosi),
        .i_oe       (1'b0),
        .o_data     (w_rx_data),
        .o_cnt      (w_rx_cnt),
        .o_sout     ()
    );

    spi_sub_shifter #(.W(DATA_W), .CNT_W(c_CNT_W)) u_tx (
        .clk        (sclk),
        .rst        (rst),
        .i_clr      (w_tx_clr),
        .i_shift    (w_tx_shift),
        .i_load     (w_tx_load),
        .i_load_val (r_wr ? r_data_o : bus.data_i),
        .i_sin      (1'b0),
        .i_oe       (w_tx_oe),
        .o_data     (),
        .o_cnt      (w_tx_cnt),
        .o_sout     (bus.miso)
    );

    assign bus.r_en      = (r_state == MEM) && !r_wr;
    assign bus.w_en      = (r_state == MEM) &&  r_wr;
    assign bus.addr      = r_addr;
    assign bus.data_o    = r_data_o;
    assign bus.frame_err = r_frame_err;
endmodule

`default_nettype wire

// File: tb/tb_spi_sub_burst.sv
// ============================================================================
// Module   : tb_spi_sub_burst
// Purpose  : Self-checking bench for spi_sub_burst (table rows, corner
//            sequences and random frames against a timing/memory model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_sub_burst;
    import spi_sub_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int H  = 2 + AW + LW;
`ifdef SPI_SUB_WR_ECHO_EN
    localparam int ECHO = 1;
`else
    localparam int ECHO = 0;
`endif
    localparam int PER_RD = DW + 2;
    localparam int PER_WR = (ECHO != 0) ? (2 * DW + 2) : (DW + 1);

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    spi_sub_burst_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    spi_sub_burst #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    // Memory seen by the DUT, and the bench's own expectation of its contents.
    logic [DW-1:0] env_mem [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];

    always @(posedge sclk) begin
        if (bus.w_en) env_mem[bus.addr] <= bus.data_o;
        if (bus.r_en) bus.data_i <= env_mem[bus.addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic cs, input logic m, input logic r);
        bus.cs_n = cs;
        bus.mosi = m;
        rst      = r;
        @(posedge sclk);
        #1;
    endtask

    logic [DW-1:0] g_wd [16];
    logic [DW-1:0] g_rx;
    int            g_strobes;

    task automatic run_frame(input logic [1:0] op, input logic [AW-1:0] a,
                             input logic [LW-1:0] len, input int abort_at,
                             input int rst_at, input int extra);
        int n, per, total, off, w, j, ws;
        logic wr, m, exp_miso, exp_r, exp_w, resp;
        logic [H-1:0]  hdr;
        logic [AW-1:0] ea;
        wr    = op[0];
        n     = op[1] ? int'(len) + 1 : 1;
        per   = wr ? PER_WR : PER_RD;
        total = H + n * per;
        hdr   = {op, a, len};
        g_strobes = 0;
        g_rx      = '0;
        for (int k = 1; k <= total + extra; k++) begin
            exp_miso = 1'b0; exp_r = 1'b0; exp_w = 1'b0; resp = 1'b0; ws = 0;
            m = 1'($urandom);
            if (k <= H)
                m = hdr[H-k];
            else if (k <= total) begin
                off = k - H - 1;
                w   = off / per;
                j   = off % per;
                ea  = a + AW'(w);
                if (wr && j < DW)
                    m = g_wd[w][DW-1-j];
                if (!wr && j >= 2) begin
                    resp = 1'b1;
                    exp_miso = ref_mem[ea][DW-1-(j-2)];
                end
                if (wr && ECHO != 0 && j >= DW + 2) begin
                    resp = 1'b1;
                    exp_miso = g_wd[w][DW-1-(j-DW-2)];
                end
            end
            if (k >= H && k < total) begin
                off = k - H;
                if (!wr && (off % per) == 0) begin
                    exp_r = 1'b1; ws = off / per;
                end else if (wr && off >= DW && ((off - DW) % per) == 0) begin
                    exp_w = 1'b1; ws = (off - DW) / per;
                end
            end
            if (k == abort_at) begin
                step(1'b1, m, 1'b0);
                chk("abort_miso", bus.miso, 0);
                chk("abort_ren", bus.r_en, 0);
                chk("abort_wen", bus.w_en, 0);
                chk("abort_ferr", bus.frame_err, 1);
                return;
            end
            if (k == rst_at) begin
                step(1'b0, m, 1'b1);
                chk("rst_miso", bus.miso, 0);
                chk("rst_ren", bus.r_en, 0);
                chk("rst_wen", bus.w_en, 0);
                chk("rst_addr", bus.addr, 0);
                chk("rst_data_o", bus.data_o, 0);
                chk("rst_ferr", bus.frame_err, 0);
                return;
            end
            step(1'b0, m, 1'b0);
            chk("miso", bus.miso, exp_miso);
            chk("r_en", bus.r_en, exp_r);
            chk("w_en", bus.w_en, exp_w);
            if (resp) g_rx = {g_rx[DW-2:0], bus.miso};
            if (k == 1) chk("ferr_clear", bus.frame_err, 0);
            if (exp_r || exp_w) begin
                g_strobes++;
                ea = a + AW'(ws);
                chk("strobe_addr", bus.addr, ea);
                if (exp_w) begin
                    chk("strobe_data", bus.data_o, g_wd[ws]);
                    ref_mem[ea] = g_wd[ws];
                end
            end
        end
        step(1'b1, 1'b0, 1'b0);
        chk("gap_ferr", bus.frame_err, 0);
        chk("gap_miso", bus.miso, 0);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [LW-1:0] len;
        logic [DW-1:0] wd0;
        int            exp_strobes;
        logic [AW-1:0] exp_last;
        logic          chk_rx;
        logic [DW-1:0] exp_rx;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic echo_on;
        echo_on = (ECHO != 0);
        tbl[0] = '{OP_WR,  10'h155, 4'd0, 32'hDEADBEEF, 1, 10'h155, echo_on, 32'hDEADBEEF};
        tbl[1] = '{OP_RD,  10'h155, 4'd5, 32'h0,        1, 10'h155, 1'b1,    32'hDEADBEEF};
        tbl[2] = '{OP_BRD, 10'h3FE, 4'd3, 32'h0,        4, 10'h001, 1'b0,    32'h0};
        tbl[3] = '{OP_BWR, 10'h010, 4'd2, 32'h1,        3, 10'h012, echo_on, 32'h3};
        tbl[4] = '{OP_BRD, 10'h010, 4'd2, 32'h0,        3, 10'h012, 1'b1,    32'h3};

        for (int i = 0; i < (1 << AW); i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        bus.cs_n   = 1'b1;
        bus.mosi   = 1'b0;
        bus.data_i = '0;

        // Reset held with cs_n low: reset must win.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("reset_miso", bus.miso, 0);
        chk("reset_ren", bus.r_en, 0);
        chk("reset_wen", bus.w_en, 0);
        chk("reset_addr", bus.addr, 0);
        chk("reset_data_o", bus.data_o, 0);
        chk("reset_ferr", bus.frame_err, 0);
        step(1'b1, 1'b0, 1'b0);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 16; i++) g_wd[i] = tbl[v].wd0 + DW'(i);
            run_frame(tbl[v].op, tbl[v].a, tbl[v].len, 0, 0, 10);
            chk("row_strobes", g_strobes, tbl[v].exp_strobes);
            chk("row_last_addr", bus.addr, tbl[v].exp_last);
            if (tbl[v].chk_rx) chk("row_rx_word", g_rx, tbl[v].exp_rx);
        end

        // Abort after 20 of 32 data bits, then a clean frame and a readback.
        g_wd[0] = 32'hCAFEF00D;
        run_frame(OP_WR, 10'h0AA, 4'd0, H + 21, 0, 0);
        g_wd[0] = 32'h12345678;
        run_frame(OP_WR, 10'h0AB, 4'd0, 0, 0, 2);
        chk("post_abort_data", bus.data_o, 32'h12345678);
        run_frame(OP_RD, 10'h0AA, 4'd0, 0, 0, 2);

        // Reset in the middle of a response, then an immediate fresh frame.
        run_frame(OP_RD, 10'h155, 4'd0, 0, H + 13, 0);
        run_frame(OP_RD, 10'h155, 4'd0, 0, 0, 3);
        chk("post_rst_rx", g_rx, 32'hDEADBEEF);

        for (int r = 0; r < 8; r++) begin
            logic [1:0]    rop;
            logic [AW-1:0] ra;
            logic [LW-1:0] rl;
            rop = 2'($urandom);
            ra  = AW'($urandom);
            rl  = LW'($urandom_range(0, 7));
            for (int i = 0; i < 16; i++) g_wd[i] = $urandom;
            run_frame(rop, ra, rl, 0, 0, int'($urandom_range(0, 3)));
            chk("rand_strobes", g_strobes, rop[1] ? int'(rl) + 1 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/spi_sub_burst.md
# spi_sub_burst

Parametrised SPI subordinate (mode 0, MSB first) that bridges an SPI master to a single-port synchronous memory. It generalises the single-word SPI memory port to configurable address/data widths and adds incrementing burst reads and writes of up to 2^LEN_W words per frame, with a sticky frame-abort flag. It sits between the chip-level SPI pads and the memory, clocked directly by `sclk`.

## Interface
- `ADDR_W`, default 10: memory address width.
- `DATA_W`, default 32: memory word width.
- `LEN_W`, default 4: burst length field width. Word count = `len`+1.

- `sclk`, input, 1: sole clock. All flops use posedge, except the `miso` flop, which uses negedge.
- `rst`, input, 1: synchronous, active-high reset.
- `cs_n`, input, 1: active-low chip select.
- `mosi`, input, 1: serial data in, sampled on posedge.
- `miso`, output, 1: serial data out, updated on negedge.
- `r_en`, output, 1: memory read strobe.
- `w_en`, output, 1: memory write strobe.
- `addr`, output, ADDR_W: memory address.
- `data_o`, output, DATA_W: write data, i.e. the last word received.
- `data_i`, input, DATA_W: read data, valid one cycle after `r_en`.
- `frame_err`, output, 1: sticky flag, set when a frame is aborted.

## Operation
- **Header:** H = 2+ADDR_W+LEN_W bits, laid out as {op[1:0], addr, len}.
- **Opcodes:**
  - 00: single read (`len` ignored).
  - 01: single write (`len` ignored).
  - 10: burst read.
  - 11: burst write.
- **States:** IDLE, HDR, WDATA, MEM, LOAD, RESP, DONE.
- **IDLE:**
  - With `cs_n`=0, the posedge samples header bit H-1 and moves to HDR.
  - The first clock of a frame carries data; no bit is dropped.
- **HDR:** shifts the remaining header bits.
  - On the last bit, load `addr` and the word counter.
  - Then go to WDATA for a write op, or MEM for a read op.
- **WDATA:** shifts DATA_W bits. The last bit loads `data_o`, then go to MEM.
- **MEM:** lasts exactly one cycle.
  - `r_en` (read op) or `w_en` (write op) is 1 for this cycle only.
  - Next state is LOAD.
- **LOAD:** one cycle.
  - The closing posedge loads the tx shift register with `data_i` (read) or `data_o` (write echo).
  - Next state is RESP.
  - Without the echo macro, writes skip LOAD and RESP (see Configuration).
- **RESP:** drives DATA_W bits on `miso`, MSB first, one per negedge.
  - After the last bit, if words remain: increment `addr` and go to MEM (read) or WDATA (write).
  - Otherwise go to DONE.
- **DONE:** further clocks are ignored and `miso`=0 until `cs_n` rises.
- **Address increment:** `addr` wraps modulo 2^ADDR_W (e.g. 0x3FF+1 → 0x000). `len` never wraps the count.
- **`cs_n` high at any posedge:**
  - State → IDLE; counters are cleared; `r_en`/`w_en` are 0.
  - If the state was HDR, WDATA, MEM, LOAD or RESP, set `frame_err`.
  - `addr` and `data_o` hold their values.
- **Frame separation:** the master provides at least one posedge with `cs_n`=1 between frames.
- **`frame_err` clear:** cleared by `rst` or by the first header bit of a new frame.
- **`miso`:** is 0 whenever the state is not RESP, and whenever `cs_n`=1 or `rst`=1 at a negedge.

## Timing
- **Reset values:** `miso`=0, `r_en`=0, `w_en`=0, `addr`=0, `data_o`=0, `frame_err`=0; state = IDLE. `rst` overrides `cs_n`.
- **Single read** (H=16, DATA_W=32), with posedge 1 as the first header bit:
  - Header occupies posedges 1–16.
  - `r_en` is high during cycle 16→17 (MEM).
  - `data_i` is captured at posedge 18.
  - The master samples response bits 31..0 on posedges 19–50.
- **Burst read:** each further word adds 34 clocks (MEM + LOAD + 32 RESP).
- **Single write with echo:**
  - Data on posedges 17–48.
  - `w_en` during cycle 48→49.
  - Echo sampled on posedges 51–82.
- **Memory strobe latency:** `r_en`/`w_en` are registered-state decodes, never asserted for two consecutive cycles. `addr` and `data_o` are stable while a strobe is high.

## Configuration
- **`SPI_SUB_WR_ECHO_EN` defined:** every write word is echoed via LOAD→RESP after its MEM cycle.
- **`SPI_SUB_WR_ECHO_EN` undefined:**
  - Writes go MEM→WDATA (or DONE) directly, and `miso` stays 0 for the whole write frame.
  - Burst write of N words = H + N·(DATA_W+1) clocks.

## Structure
- **Package `spi_sub_pkg`:** holds the `state_t` enum and `op_t` enum (OP_RD=2'b00, OP_WR=2'b01, OP_BRD=2'b10, OP_BWR=2'b11).
- **Sub-module `spi_sub_shifter`:** parametrised width, with bit counter, shift-in, parallel-load and shift-out on negedge. Two instances:
  - rx: header/data.
  - tx: response.

## Test plan
- **Single write then single read:** write 0xDEADBEEF @0x155, then read @0x155.
  - One `w_en` pulse with `addr`=0x155 and `data_o`=0xDEADBEEF.
  - The read response bits equal 0xDEADBEEF.
- **Burst read:** `len`=3 @0x3FE.
  - `r_en` pulses at addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - The four response words match memory; then DONE and `miso`=0.
- **Burst write:** `len`=2 @0x010, words 1, 2, 3.
  - `w_en` pulses at 0x010/0x011/0x012 with matching `data_o`.
  - Echo words match when `SPI_SUB_WR_ECHO_EN` is defined; `miso` stays 0 when it is not.
- **Abort:** `cs_n` rises after 20 of 32 WDATA bits.
  - No `w_en`; `frame_err`=1; state = IDLE.
  - The next valid frame clears `frame_err` and completes correctly.
- **Reset mid-RESP:** assert `rst` for one posedge.
  - All outputs return to reset values.
  - A fresh frame started afterwards with `cs_n` low works correctly.
- **Extra clocks after DONE:** 10 extra clocks produce no strobes and keep `miso`=0.
